// File: rtl/jt900h_pkg.sv
// Shared definitions for the JT900H bus arbiter: sequencer states, access lengths,
// requester identifiers and small helpers for beat counting and read masking.
package jt900h_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_RDL  = 3'd2,
        ST_WR   = 3'd3,
        ST_ACK  = 3'd4
    } busarb_state_t;

    localparam logic [2:0] LEN_BYTE = 3'd1;
    localparam logic [2:0] LEN_WORD = 3'd2;
    localparam logic [2:0] LEN_LONG = 3'd4;

    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_DATA  = 1'b1;

    // Any byte count other than 2 or 4 is handled as a single byte.
    function automatic logic [2:0] norm_len(input logic [2:0] len);
        case (len)
            LEN_WORD: norm_len = LEN_WORD;
            LEN_LONG: norm_len = LEN_LONG;
            default:  norm_len = LEN_BYTE;
        endcase
    endfunction

    function automatic logic [1:0] beat_count(input logic a0, input logic [2:0] len);
        logic [3:0] sum;
        sum = {3'd0, a0} + {1'b0, len} + 4'd1;
        beat_count = sum[2:1];
    endfunction

    function automatic logic [31:0] len_mask(input logic [2:0] len);
        case (len)
            LEN_BYTE: len_mask = 32'h0000_00FF;
            LEN_WORD: len_mask = 32'h0000_FFFF;
            default:  len_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/jt900h_busarb_lanes.sv
// Byte-lane write-enable mask and write-data alignment for one 16-bit RAM beat,
// given the access alignment, normalised byte count and beat index.
module jt900h_busarb_lanes
    import jt900h_pkg::*;
(
    input  logic        a0,
    input  logic [2:0]  len,
    input  logic [1:0]  beat,
    input  logic [31:0] din,
    output logic [1:0]  we,
    output logic [15:0] wdata
);

    logic [47:0] shifted;
    logic [5:0]  mask;

    // Lay the access out across the three halfwords it can touch, then pick this beat.
    always_comb begin
        shifted = a0 ? {8'd0, din, 8'd0} : {16'd0, din};
        case (len)
            LEN_BYTE: mask = 6'b000001;
            LEN_WORD: mask = 6'b000011;
            default:  mask = 6'b001111;
        endcase
        if (a0) mask = {mask[4:0], 1'b0};
        case (beat)
            2'd0: begin we = mask[1:0]; wdata = shifted[15:0];  end
            2'd1: begin we = mask[3:2]; wdata = shifted[31:16]; end
            2'd2: begin we = mask[5:4]; wdata = shifted[47:32]; end
            default: begin we = 2'b00; wdata = 16'd0; end
        endcase
    end

endmodule

// File: rtl/jt900h_busarb.sv
// Shares the single 16-bit RAM port between instruction fetch and data accesses,
// splitting unaligned 1/2/4-byte accesses into RAM beats and assembling read data.
module jt900h_busarb
    import jt900h_pkg::*;
#(
    parameter int AW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [15:0]   if_data,
    input  logic          dt_req,
    input  logic          dt_we,
    input  logic [2:0]    dt_len,
    input  logic [AW-1:0] dt_addr,
    input  logic [31:0]   dt_din,
    output logic          dt_ack,
    output logic [31:0]   dt_dout,
    output logic [AW-1:0] ram_addr,
    input  logic [15:0]   ram_dout,
    output logic [15:0]   ram_din,
    output logic [1:0]    ram_we,
    output logic          busy
);

    busarb_state_t state;
    logic          last;
    logic          cur;
    logic [2:0]    q_len;
    logic          q_a0;
    logic [31:0]   q_din;
    logic [1:0]    beat;
    logic [1:0]    nbeats;
    logic [31:0]   rd_buf;

    logic          grant_dt;
    logic          lane_a0;
    logic [2:0]    lane_len;
    logic [1:0]    lane_beat;
    logic [31:0]   lane_din;
    logic [1:0]    lane_we;
    logic [15:0]   lane_wdata;
    logic [47:0]   rd_full;
    logic [5:0]    shamt;
    logic [31:0]   rd_data;

    // On a tie the requester that was not served last wins.
    assign grant_dt = dt_req & (~if_req | (last == REQ_FETCH));

    // Lane logic looks at the live request while granting, otherwise at the next beat.
    always_comb begin
        lane_a0   = q_a0;
        lane_len  = q_len;
        lane_din  = q_din;
        lane_beat = beat + 2'd1;
        if (state == ST_IDLE) begin
            lane_a0   = dt_addr[0];
            lane_len  = norm_len(dt_len);
            lane_din  = dt_din;
            lane_beat = 2'd0;
        end
    end

    jt900h_busarb_lanes u_lanes (
        .a0    (lane_a0),
        .len   (lane_len),
        .beat  (lane_beat),
        .din   (lane_din),
        .we    (lane_we),
        .wdata (lane_wdata)
    );

    // The freshest words sit at the top of rd_full; realign to the first requested byte.
    always_comb begin
        rd_full = {ram_dout, rd_buf};
        shamt   = {2'd3 - nbeats, 4'd0} + {2'd0, q_a0, 3'd0};
        rd_data = 32'(rd_full >> shamt) & len_mask(q_len);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            last     <= REQ_FETCH;
            cur      <= REQ_FETCH;
            q_len    <= LEN_BYTE;
            q_a0     <= 1'b0;
            q_din    <= 32'd0;
            beat     <= 2'd0;
            nbeats   <= 2'd0;
            rd_buf   <= 32'd0;
            if_ack   <= 1'b0;
            if_data  <= 16'd0;
            dt_ack   <= 1'b0;
            dt_dout  <= 32'd0;
            ram_addr <= '0;
            ram_din  <= 16'd0;
            ram_we   <= 2'b00;
            busy     <= 1'b0;
        end else if (cen) begin
            if_ack <= 1'b0;
            dt_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (if_req || dt_req) begin
                        busy <= 1'b1;
                        beat <= 2'd0;
                        if (grant_dt) begin
                            cur      <= REQ_DATA;
                            last     <= REQ_DATA;
                            q_len    <= norm_len(dt_len);
                            q_a0     <= dt_addr[0];
                            q_din    <= dt_din;
                            nbeats   <= beat_count(dt_addr[0], norm_len(dt_len));
                            ram_addr <= {dt_addr[AW-1:1], 1'b0};
                            if (dt_we) begin
                                state   <= ST_WR;
                                ram_we  <= lane_we;
                                ram_din <= lane_wdata;
                            end else begin
                                state <= ST_RD;
                            end
                        end else begin
                            cur      <= REQ_FETCH;
                            last     <= REQ_FETCH;
                            q_len    <= LEN_WORD;
                            q_a0     <= if_addr[0];
                            q_din    <= 32'd0;
                            nbeats   <= beat_count(if_addr[0], LEN_WORD);
                            ram_addr <= {if_addr[AW-1:1], 1'b0};
                            state    <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (beat != 2'd0) rd_buf <= {ram_dout, rd_buf[31:16]};
                    if (beat == nbeats - 2'd1) begin
                        state <= ST_RDL;
                    end else begin
                        beat     <= beat + 2'd1;
                        ram_addr <= ram_addr + AW'(2);
                    end
                end
                ST_RDL: begin
                    if (cur == REQ_DATA) begin
                        dt_dout <= rd_data;
                        dt_ack  <= 1'b1;
                    end else begin
                        if_data <= rd_data[15:0];
                        if_ack  <= 1'b1;
                    end
                    state <= ST_ACK;
                end
                ST_WR: begin
                    if (beat == nbeats - 2'd1) begin
                        ram_we <= 2'b00;
                        dt_ack <= 1'b1;
                        state  <= ST_ACK;
                    end else begin
                        beat     <= beat + 2'd1;
                        ram_addr <= ram_addr + AW'(2);
                        ram_we   <= lane_we;
                        ram_din  <= lane_wdata;
                    end
                end
                ST_ACK: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
